// File: rtl/frac_pkg.sv
// frac_pkg: shared FSM state type and default operand width for fraction_reduce
package frac_pkg;
  localparam int FRAC_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, DIV_M, DIV_N, DONE} state_t;
endpackage

// File: rtl/restoring_div_step.sv
// restoring_div_step: one MSB-first restoring division step (i_rem/i_bit/i_div in, o_rem/o_q out)
module restoring_div_step
  import frac_pkg::*;
#(
  parameter int WIDTH = FRAC_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q
);
  logic [WIDTH+1:0] w_sh, w_diff;
  assign w_sh   = {i_rem, i_bit};
  assign w_diff = w_sh - {2'b00, i_div};
  assign o_q    = ~w_diff[WIDTH+1];
  assign o_rem  = o_q ? w_diff[WIDTH:0] : w_sh[WIDTH:0];
endmodule

// File: rtl/fraction_reduce.sv
// fraction_reduce: P=M/G, Q=N/G through one shared restoring divider, TC/err/busy status; FRAC_REM_CHECK_EN also flags nonzero remainders
module fraction_reduce
  import frac_pkg::*;
#(
  parameter int WIDTH = FRAC_WIDTH
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             load,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             TC,
  output logic             err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_m, r_n, r_g;
  logic [WIDTH:0] r_rem, w_rem;
  logic [CW-1:0] r_cnt;
  logic r_err, w_q, w_bit, w_last;
`ifdef FRAC_REM_CHECK_EN
  logic r_mnz;
`endif
  assign w_last = r_cnt == LAST;
  assign w_bit  = r_state == DIV_N ? r_n[WIDTH-1] : r_m[WIDTH-1];
  assign busy   = r_state == DIV_M || r_state == DIV_N;
  assign TC     = r_state == DONE;
  assign err    = r_err;
  assign P      = r_m;
  assign Q      = r_n;
  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem(r_rem),
    .i_bit(w_bit),
    .i_div(r_g),
    .o_rem(w_rem),
    .o_q  (w_q)
  );
  always_comb begin
    w_next = r_state;
    if (load) w_next = G == '0 ? DONE : DIV_M;
    else if (r_state == DIV_M && w_last) w_next = DIV_N;
    else if (r_state == DIV_N && w_last) w_next = DONE;
  end
  always_ff @(posedge clk) r_state <= sync_reset ? IDLE : w_next;
  // r_m/r_n shift the dividend out of the top and the quotient in at the bottom
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_m   <= '0;
      r_n   <= '0;
      r_g   <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
`ifdef FRAC_REM_CHECK_EN
      r_mnz <= 1'b0;
`endif
    end else if (load) begin
      r_m   <= M;
      r_n   <= N;
      r_g   <= G;
      r_rem <= '0;
      r_cnt <= '0;
      r_err <= G == '0;
`ifdef FRAC_REM_CHECK_EN
      r_mnz <= 1'b0;
`endif
    end else if (busy) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      r_rem <= w_last ? '0 : w_rem;
      if (r_state == DIV_M) r_m <= {r_m[WIDTH-2:0], w_q};
      else r_n <= {r_n[WIDTH-2:0], w_q};
`ifdef FRAC_REM_CHECK_EN
      if (w_last && r_state == DIV_M) r_mnz <= |w_rem;
      if (w_last && r_state == DIV_N) r_err <= r_mnz | (|w_rem);
`endif
    end
  end
endmodule

// File: tb/tb_fraction_reduce.sv
// tb_fraction_reduce: table-driven and randomized checks of fraction_reduce against an arithmetic model
module tb_fraction_reduce;
  localparam int W = 8;
`ifdef FRAC_REM_CHECK_EN
  localparam bit REMCHK = 1'b1;
`else
  localparam bit REMCHK = 1'b0;
`endif
  logic clk = 1'b0, sync_reset = 1'b1, load = 1'b0;
  logic [W-1:0] M = '0, N = '0, G = '0;
  logic [W-1:0] P, Q;
  logic busy, TC, err;
  int checks = 0, errors = 0;
  typedef struct {
    logic [W-1:0] m, n, g, p, q;
    logic e;
  } vec_t;
  vec_t tbl [5];
  always #5 clk = ~clk;
  fraction_reduce #(.WIDTH(W)) dut (
    .clk(clk), .sync_reset(sync_reset), .load(load),
    .M(M), .N(N), .G(G), .P(P), .Q(Q), .busy(busy), .TC(TC), .err(err)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic model(input int m, input int n, input int g, output int p, output int q, output int e);
    if (g == 0) begin
      p = m; q = n; e = 1;
    end else begin
      p = m / g; q = n / g;
      e = REMCHK && ((m % g) != 0 || (n % g) != 0) ? 1 : 0;
    end
  endtask
  task automatic run_op(input int m, input int n, input int g, input int ep, input int eq, input int ee, input string name);
    int edges, bad, lat;
    lat = g == 0 ? 1 : 2 * W + 1;
    load = 1'b1; M = W'(m); N = W'(n); G = W'(g);
    step();
    load = 1'b0;
    edges = 1; bad = 0;
    while (!TC && edges < 40) begin
      if (!busy) bad++;
      step();
      edges++;
    end
    chk({name, ".latency"}, edges, lat);
    chk({name, ".busy_during"}, bad, 0);
    chk({name, ".busy_done"}, int'(busy), 0);
    chk({name, ".P"}, int'(P), ep);
    chk({name, ".Q"}, int'(Q), eq);
    chk({name, ".err"}, int'(err), ee);
    M = ~M; N = ~N; G = ~G;
    step(); step();
    chk({name, ".hold"}, int'({TC, err, P, Q}), int'({1'b1, 1'(ee), W'(ep), W'(eq)}));
  endtask
  initial begin
    int p, q, e, m, n, g;
    tbl[0] = '{m: 12, n: 18, g: 6, p: 2, q: 3, e: 1'b0};
    tbl[1] = '{m: 255, n: 255, g: 255, p: 1, q: 1, e: 1'b0};
    tbl[2] = '{m: 7, n: 9, g: 1, p: 7, q: 9, e: 1'b0};
    tbl[3] = '{m: 5, n: 10, g: 0, p: 5, q: 10, e: 1'b1};
    tbl[4] = '{m: 12, n: 18, g: 4, p: 3, q: 4, e: REMCHK};
    step(); step();
    sync_reset = 1'b0;
    chk("reset.outs", int'({P, Q, busy, TC, err}), 0);
    step();
    chk("idle.hold", int'({P, Q, busy, TC, err}), 0);
    for (int i = 0; i < 5; i++)
      run_op(tbl[i].m, tbl[i].n, tbl[i].g, tbl[i].p, tbl[i].q, tbl[i].e, $sformatf("tbl%0d", i));
    load = 1'b1; M = 12; N = 18; G = 6;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("restart.noTC", int'(TC), 0);
    end
    run_op(40, 64, 8, 5, 8, 0, "restart");
    load = 1'b1; M = 12; N = 18; G = 6;
    step();
    load = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("reset.busy_before", int'(busy), 1);
    sync_reset = 1'b1;
    step();
    chk("reset.mid", int'({P, Q, busy, TC, err}), 0);
    load = 1'b1; M = 9; N = 3; G = 0;
    step();
    chk("reset.vs_load", int'({P, Q, busy, TC, err}), 0);
    sync_reset = 1'b0; load = 1'b0;
    step(); step();
    chk("reset.idle", int'({P, Q, busy, TC, err}), 0);
    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(0, 255);
      n = $urandom_range(0, 255);
      g = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      if (g != 0 && $urandom_range(0, 1) == 1) begin
        g = $urandom_range(1, 20);
        m = (m / g) * g;
        n = (n / g) * g;
      end
      model(m, n, g, p, q, e);
      run_op(m, n, g, p, q, e, $sformatf("rnd%0d", i));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
